player_move_ctrl: RTL and testbench

//  Upstream stage of the score/display block: turns raw push-buttons into validated

---
 rtl/player_move_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_player_move_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// Push-button to validated maze step controller: sync, debounce, edge detect, wall-check handshake.
// Optional ack timeout enabled by defining MOVE_ACK_TIMEOUT_EN.
module player_move_ctrl #(
  parameter int unsigned X_W     = 4,
  parameter int unsigned Y_W     = 4,
  parameter int unsigned MAZE_W  = 16,
  parameter int unsigned MAZE_H  = 12,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0,
  parameter int unsigned EXIT_X  = 15,
  parameter int unsigned EXIT_Y  = 11,
  parameter int unsigned DB_CYC  = 50000,
  parameter int unsigned TO_CYC  = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  output logic           wall_req,
  output logic [X_W-1:0] wall_x,
  output logic [Y_W-1:0] wall_y,
  input  logic           wall_ack,
  input  logic           wall_hit,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           move,
  output logic           win,
  output logic           busy
);

  localparam int unsigned CW = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;

  if (DB_CYC < 2 || TO_CYC < 1 || TO_CYC > 255 ||
      MAZE_W > (1 << X_W) || MAZE_H > (1 << Y_W)) begin : g_param_check
    $error("player_move_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, REQ, WON} state_t;

  // Button index: 3=up, 2=down, 1=left, 0=right (bit order matches priority)
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q, sync2_q, level_q, prev_q;
  logic [3:0]    level_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    press;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};
  assign press   = level_q & ~prev_q;

  // Counter tracks consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts it.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CW'(DB_CYC - 1)) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  state_t         state_q, state_d;
  logic           wall_req_q, wall_req_d;
  logic [X_W-1:0] wall_x_q, wall_x_d, pos_x_q, pos_x_d, tgt_x;
  logic [Y_W-1:0] wall_y_q, wall_y_d, pos_y_q, pos_y_d, tgt_y;
  logic           move_q, move_d, win_q, win_d, busy_q, busy_d;
  logic           tgt_ok;

  // Direction select with bounds checked before any +/-1, so coordinates never wrap.
  always_comb begin
    tgt_x  = pos_x_q;
    tgt_y  = pos_y_q;
    tgt_ok = 1'b0;
    if (press[3]) begin
      tgt_ok = (pos_y_q != '0);
      if (tgt_ok) tgt_y = pos_y_q - Y_W'(1);
    end else if (press[2]) begin
      tgt_ok = (pos_y_q != Y_W'(MAZE_H - 1));
      if (tgt_ok) tgt_y = pos_y_q + Y_W'(1);
    end else if (press[1]) begin
      tgt_ok = (pos_x_q != '0);
      if (tgt_ok) tgt_x = pos_x_q - X_W'(1);
    end else if (press[0]) begin
      tgt_ok = (pos_x_q != X_W'(MAZE_W - 1));
      if (tgt_ok) tgt_x = pos_x_q + X_W'(1);
    end
  end

`ifdef MOVE_ACK_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    wall_req_d = wall_req_q;
    wall_x_d   = wall_x_q;
    wall_y_d   = wall_y_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    move_d     = 1'b0;
    win_d      = win_q;
    busy_d     = busy_q;
`ifdef MOVE_ACK_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (tgt_ok) begin
          state_d    = REQ;
          wall_req_d = 1'b1;
          wall_x_d   = tgt_x;
          wall_y_d   = tgt_y;
          busy_d     = 1'b1;
`ifdef MOVE_ACK_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (wall_ack) begin
          wall_req_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
          if (!wall_hit) begin
            pos_x_d = wall_x_q;
            pos_y_d = wall_y_q;
            move_d  = 1'b1;
            if (wall_x_q == X_W'(EXIT_X) && wall_y_q == Y_W'(EXIT_Y)) begin
              win_d   = 1'b1;
              state_d = WON;
            end
          end
`ifdef MOVE_ACK_TIMEOUT_EN
        end else if (to_cnt_q == 8'(TO_CYC - 1)) begin
          wall_req_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
`endif
        end
      end
      WON: begin
        wall_req_d = 1'b0;
        busy_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wall_req_q <= 1'b0;
      wall_x_q   <= '0;
      wall_y_q   <= '0;
      pos_x_q    <= X_W'(START_X);
      pos_y_q    <= Y_W'(START_Y);
      move_q     <= 1'b0;
      win_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MOVE_ACK_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wall_req_q <= wall_req_d;
      wall_x_q   <= wall_x_d;
      wall_y_q   <= wall_y_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      move_q     <= move_d;
      win_q      <= win_d;
      busy_q     <= busy_d;
`ifdef MOVE_ACK_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign wall_req = wall_req_q;
  assign wall_x   = wall_x_q;
  assign wall_y   = wall_y_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign move     = move_q;
  assign win      = win_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: directed scenarios plus a random walk
// checked against a grid-position model.
module tb_player_move_ctrl;
  localparam int MW = 16, MH = 12, EX = 15, EY = 11;

  logic       clk = 1'b0, rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       wall_ack = 1'b0, wall_hit = 1'b0;
  logic       wall_req, move, win, busy;
  logic [3:0] wall_x, wall_y, pos_x, pos_y;

  int n_cmp = 0, n_bad = 0, move_cnt = 0;
  int mx = 0, my = 0;
  bit mwon = 1'b0;

  player_move_ctrl #(.DB_CYC(4), .TO_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .pos_x(pos_x), .pos_y(pos_y), .move(move), .win(win), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (move === 1'b1) move_cnt++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_btn(input int dir, input bit v);
    case (dir)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  // Model: 0=up(y-1) 1=down(y+1) 2=left(x-1) 3=right(x+1); legal if target inside grid
  function automatic bit legal(input int dir, input int x, input int y,
                               output int tx, output int ty);
    tx = x + ((dir == 3) ? 1 : 0) - ((dir == 2) ? 1 : 0);
    ty = y + ((dir == 1) ? 1 : 0) - ((dir == 0) ? 1 : 0);
    return (tx >= 0) && (tx < MW) && (ty >= 0) && (ty < MH);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = '0;
    wall_ack = 1'b0; wall_hit = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    mx = 0; my = 0; mwon = 1'b0;
    tick();
  endtask

  task automatic step(input int dir, input bit hit, input int dly, input int hold, input string tag);
    int tx, ty, m0;
    bit ok, seen, late;
    ok = legal(dir, mx, my, tx, ty) && !mwon;
    m0 = move_cnt;
    seen = 1'b0;
    set_btn(dir, 1'b1);
    for (int i = 0; i < 25 && !seen; i++) begin
      tick();
      if (wall_req === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== ok) begin
      n_bad++; $display("FAIL %s req_seen got %0b want %0b", tag, seen, ok);
    end
    if (seen && ok) begin
      n_cmp++;
      if (wall_x !== tx[3:0] || wall_y !== ty[3:0] || busy !== 1'b1) begin
        n_bad++; $display("FAIL %s target got (%0d,%0d) busy=%0b want (%0d,%0d) busy=1",
                          tag, wall_x, wall_y, busy, tx, ty);
      end
      repeat (dly) tick();
      n_cmp++;
      if (wall_req !== 1'b1 || wall_x !== tx[3:0] || wall_y !== ty[3:0]) begin
        n_bad++; $display("FAIL %s hold got req=%0b (%0d,%0d) want req=1 (%0d,%0d)",
                          tag, wall_req, wall_x, wall_y, tx, ty);
      end
      wall_ack = 1'b1; wall_hit = hit;
      tick();
      wall_ack = 1'b0; wall_hit = 1'b0;
      if (!hit) begin
        mx = tx; my = ty;
        if (tx == EX && ty == EY) mwon = 1'b1;
      end
      n_cmp++;
      if (pos_x !== 4'(mx) || pos_y !== 4'(my) || move !== !hit || wall_req !== 1'b0 || win !== mwon) begin
        n_bad++; $display("FAIL %s ack got pos=(%0d,%0d) move=%0b req=%0b win=%0b want (%0d,%0d) %0b 0 %0b",
                          tag, pos_x, pos_y, move, wall_req, win, mx, my, !hit, mwon);
      end
      tick();
      n_cmp++;
      if (move !== 1'b0) begin
        n_bad++; $display("FAIL %s move_width got %0b want 0", tag, move);
      end
    end else if (seen) begin
      wall_ack = 1'b1; wall_hit = 1'b1; tick(); wall_ack = 1'b0; wall_hit = 1'b0;
    end
    late = 1'b0;
    repeat (hold) begin tick(); if (wall_req !== 1'b0) late = 1'b1; end
    set_btn(dir, 1'b0);
    repeat (12) begin tick(); if (wall_req !== 1'b0) late = 1'b1; end
    n_cmp++;
    if (late || (move_cnt - m0) != int'(ok && !hit)) begin
      n_bad++; $display("FAIL %s moves got %0d extra_req=%0b want %0d extra_req=0",
                        tag, move_cnt - m0, late, int'(ok && !hit));
    end
  endtask

  task automatic goto_cell(input int x, input int y);
    while (mx < x) step(3, 1'b0, $urandom_range(0, 3), 0, "goto_r");
    while (mx > x) step(2, 1'b0, $urandom_range(0, 3), 0, "goto_l");
    while (my < y) step(1, 1'b0, $urandom_range(0, 3), 0, "goto_d");
    while (my > y) step(0, 1'b0, $urandom_range(0, 3), 0, "goto_u");
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (pos_x !== 4'd0 || pos_y !== 4'd0 || move !== 1'b0 || win !== 1'b0 || wall_req !== 1'b0 ||
        busy !== 1'b0 || wall_x !== 4'd0 || wall_y !== 4'd0) begin
      n_bad++; $display("FAIL reset got pos=(%0d,%0d) mv=%0b win=%0b req=%0b busy=%0b wall=(%0d,%0d) want all 0",
                        pos_x, pos_y, move, win, wall_req, busy, wall_x, wall_y);
    end
    do_reset();
  endtask

  task automatic test_bounce();
    bit seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      btn_right = 1'b1;
      repeat ($urandom_range(1, 3)) begin tick(); if (wall_req !== 1'b0) seen = 1'b1; end
      btn_right = 1'b0;
      repeat ($urandom_range(1, 4)) begin tick(); if (wall_req !== 1'b0) seen = 1'b1; end
    end
    repeat (12) begin tick(); if (wall_req !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen || pos_x !== 4'd0) begin
      n_bad++; $display("FAIL bounce got req_seen=%0b pos_x=%0d want 0 0", seen, pos_x);
    end
  endtask

  task automatic test_priority_and_busy_press();
    bit seen = 1'b0, bad = 1'b0;
    int m0 = move_cnt;
    btn_up = 1'b1; btn_right = 1'b1;
    for (int i = 0; i < 25 && !seen; i++) begin tick(); if (wall_req === 1'b1) seen = 1'b1; end
    n_cmp++;
    if (!seen || wall_x !== 4'd5 || wall_y !== 4'd4) begin
      n_bad++; $display("FAIL prio got req=%0b (%0d,%0d) want 1 (5,4)", seen, wall_x, wall_y);
    end
    btn_up = 1'b0; btn_right = 1'b0; btn_left = 1'b1;
    repeat (12) begin tick(); if (wall_req !== 1'b1 || wall_x !== 4'd5 || wall_y !== 4'd4) bad = 1'b1; end
    btn_left = 1'b0;
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL busy_press got target disturbed want held (5,4)"); end
    wall_ack = 1'b1; wall_hit = 1'b0; tick(); wall_ack = 1'b0;
    my = 4;
    n_cmp++;
    if (pos_x !== 4'd5 || pos_y !== 4'd4 || move !== 1'b1) begin
      n_bad++; $display("FAIL prio_ack got (%0d,%0d) move=%0b want (5,4) 1", pos_x, pos_y, move);
    end
    bad = 1'b0;
    repeat (20) begin tick(); if (wall_req !== 1'b0) bad = 1'b1; end
    n_cmp++;
    if (bad || move_cnt - m0 != 1) begin
      n_bad++; $display("FAIL prio_count got moves=%0d extra_req=%0b want 1 0", move_cnt - m0, bad);
    end
  endtask

  task automatic test_random_walk();
    int tx, ty;
    for (int k = 0; k < 30; k++) begin
      int dir = $urandom_range(0, 3);
      bit hit = ($urandom_range(0, 3) == 0);
      if (legal(dir, mx, my, tx, ty) && tx == EX && ty == EY) hit = 1'b1;
      step(dir, hit, $urandom_range(0, 5), $urandom_range(0, 5), "rand");
    end
  endtask

  task automatic test_win();
    goto_cell(14, 11);
    step(3, 1'b0, 2, 0, "win_step");
    for (int d = 0; d < 4; d++) step(d, 1'b0, 0, 0, "won_press");
    n_cmp++;
    if (win !== 1'b1 || pos_x !== 4'd15 || pos_y !== 4'd11) begin
      n_bad++; $display("FAIL won_hold got win=%0b (%0d,%0d) want 1 (15,11)", win, pos_x, pos_y);
    end
    rst = 1'b0; #1;
    n_cmp++;
    if (win !== 1'b0 || pos_x !== 4'd0 || pos_y !== 4'd0) begin
      n_bad++; $display("FAIL win_reset got win=%0b (%0d,%0d) want 0 (0,0)", win, pos_x, pos_y);
    end
    do_reset();
  endtask

  task automatic wait_req(input string tag);
    bit seen = 1'b0;
    btn_right = 1'b1;
    for (int i = 0; i < 25 && !seen; i++) begin tick(); if (wall_req === 1'b1) seen = 1'b1; end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL %s got req=0 want 1", tag); end
  endtask

  task automatic test_timeout_and_midreq_reset();
    int m0;
    do_reset();
    m0 = move_cnt;
    wait_req("to_req");
`ifdef MOVE_ACK_TIMEOUT_EN
    begin
      bit bad = 1'b0;
      repeat (7) begin tick(); if (wall_req !== 1'b1) bad = 1'b1; end
      tick(); if (wall_req !== 1'b0) bad = 1'b1;
      n_cmp++;
      if (bad) begin n_bad++; $display("FAIL timeout got req not dropping after 8 cycles want drop"); end
      btn_right = 1'b0;
      wall_ack = 1'b1; tick(); wall_ack = 1'b0; tick();
      n_cmp++;
      if (pos_x !== 4'd0 || move_cnt != m0 || wall_req !== 1'b0) begin
        n_bad++; $display("FAIL late_ack got pos_x=%0d moves=%0d req=%0b want 0 0 0", pos_x, move_cnt - m0, wall_req);
      end
      repeat (12) tick();
      wait_req("to_req2");
    end
`else
    repeat (100) tick();
    n_cmp++;
    if (wall_req !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL no_timeout got req=%0b busy=%0b want 1 1", wall_req, busy);
    end
`endif
    rst = 1'b0; #1;
    n_cmp++;
    if (wall_req !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreq_reset got req=%0b busy=%0b want 0 0", wall_req, busy);
    end
    btn_right = 1'b0;
    do_reset();
    n_cmp++;
    if (wall_req !== 1'b0 || pos_x !== 4'd0 || move_cnt != m0) begin
      n_bad++; $display("FAIL post_reset got req=%0b pos_x=%0d moves=%0d want 0 0 0", wall_req, pos_x, move_cnt - m0);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    step(2, 1'b0, 0, 0, "offgrid_left");
    step(0, 1'b0, 0, 0, "offgrid_up");
    step(3, 1'b0, 3, 10, "right_step");
    step(1, 1'b1, 2, 0, "wall_hit");
    goto_cell(5, 5);
    test_priority_and_busy_press();
    test_random_walk();
    test_win();
    test_timeout_and_midreq_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
